// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALUOp, funct, alu_ctr codes and FSM states for the ALU issue unit
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  localparam logic [3:0] CTR_AND     = 4'b0000;
  localparam logic [3:0] CTR_OR      = 4'b0001;
  localparam logic [3:0] CTR_ADD     = 4'b0010;
  localparam logic [3:0] CTR_SUB     = 4'b0110;
  localparam logic [3:0] CTR_SLT     = 4'b0111;
  localparam logic [3:0] CTR_NOR     = 4'b1100;
  localparam logic [3:0] CTR_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } issue_state_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// rtl/alu_issue_unit_if.sv - request/response handshake bundle of the ALU issue unit
interface alu_issue_unit_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_aluop;
  logic [5:0]       req_funct;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_res;
  logic             resp_zero;
  logic             resp_err;

  modport master (
    output req_valid, req_a, req_b, req_aluop, req_funct, resp_ready,
    input  req_ready, resp_valid, resp_res, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_aluop, req_funct, resp_ready,
    output req_ready, resp_valid, resp_res, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/funct to alu_ctr decode with illegal flag
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctr,
  output logic       illegal
);

  always_comb begin
    alu_ctr = CTR_ADD;
    illegal = 1'b0;
    unique case (aluop)
      ALUOP_ADD: alu_ctr = CTR_ADD;
      ALUOP_SUB: alu_ctr = CTR_SUB;
      ALUOP_OR:  alu_ctr = CTR_OR;
      default: begin
        case (funct)
          FUNCT_ADD: alu_ctr = CTR_ADD;
          FUNCT_SUB: alu_ctr = CTR_SUB;
          FUNCT_AND: alu_ctr = CTR_AND;
          FUNCT_OR:  alu_ctr = CTR_OR;
          FUNCT_SLT: alu_ctr = CTR_SLT;
          FUNCT_NOR: alu_ctr = CTR_NOR;
          default: begin
            alu_ctr = CTR_ILLEGAL;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - one-deep issue stage driving an external combinational ALU
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_unit_if.slave  io,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero
);

  issue_state_t     state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]       ctr_q, ctr_d;
  logic             illegal_q, illegal_d, zero_q, zero_d, err_q, err_d;
  logic [3:0]       dec_ctr;
  logic             dec_illegal;

  alu_ctrl_decode u_decode (
    .aluop   (io.req_aluop),
    .funct   (io.req_funct),
    .alu_ctr (dec_ctr),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ctr_d     = ctr_q;
    illegal_d = illegal_q;
    res_d     = res_q;
    zero_d    = zero_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (io.req_valid) begin
          a_d       = io.req_a;
          b_d       = io.req_b;
          ctr_d     = dec_ctr;
          illegal_d = dec_illegal;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // An illegal decode never trusts the ALU; it reports a fixed zero result.
        res_d   = illegal_q ? '0 : alu_res;
        zero_d  = illegal_q ? 1'b1 : alu_zero;
        err_d   = illegal_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (io.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      ctr_q     <= CTR_ADD;
      illegal_q <= 1'b0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctr_q     <= ctr_d;
      illegal_q <= illegal_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
    end
  end

  assign io.req_ready  = (state_q == ST_IDLE);
  assign io.resp_valid = (state_q == ST_RESP);
  assign io.resp_res   = res_q;
  assign io.resp_zero  = zero_q;
  assign io.resp_err   = err_q;
  assign alu_input1    = a_q;
  assign alu_input2    = b_q;
  assign alu_ctr       = ctr_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - directed self-checking bench for alu_issue_unit with a behavioural ALU
module tb_alu_issue_unit;

  logic        clk;
  logic        reset;
  logic [31:0] alu_input1, alu_input2, alu_res;
  logic [3:0]  alu_ctr;
  logic        alu_zero;
  int          nvec;
  int          nmis;

  alu_issue_unit_if #(.WIDTH(32)) bus ();

  alu_issue_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .io         (bus),
    .alu_input1 (alu_input1),
    .alu_input2 (alu_input2),
    .alu_ctr    (alu_ctr),
    .alu_res    (alu_res),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Team ALU: unknown controls return a poison value that must never surface.
  always_comb begin
    case (alu_ctr)
      4'b0000: alu_res = alu_input1 & alu_input2;
      4'b0001: alu_res = alu_input1 | alu_input2;
      4'b0010: alu_res = alu_input1 + alu_input2;
      4'b0110: alu_res = alu_input1 - alu_input2;
      4'b0111: alu_res = ($signed(alu_input1) < $signed(alu_input2)) ? 32'd1 : 32'd0;
      4'b1100: alu_res = ~(alu_input1 | alu_input2);
      default: alu_res = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] aluop, input logic [5:0] funct,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] exp_ctr, input logic [31:0] exp_res,
                       input logic exp_zero, input logic exp_err);
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_aluop = aluop;
    bus.req_funct = funct;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("exec_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("exec_req_ready", 32'(bus.req_ready), 32'd0);
    chk("exec_alu_ctr", 32'(alu_ctr), 32'(exp_ctr));
    chk("exec_alu_in1", alu_input1, a);
    chk("exec_alu_in2", alu_input2, b);
    @(posedge clk);
    @(negedge clk);
    chk("resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("resp_res", bus.resp_res, exp_res);
    chk("resp_zero", 32'(bus.resp_zero), 32'(exp_zero));
    chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("post_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("post_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    reset = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_aluop  = 2'b00;
    bus.req_funct  = 6'd0;
    bus.req_a      = 32'h1111_1111;
    bus.req_b      = 32'h2222_2222;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_res", bus.resp_res, 32'd0);
    chk("rst_resp_zero", 32'(bus.resp_zero), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_alu_in1", alu_input1, 32'd0);
    chk("rst_alu_in2", alu_input2, 32'd0);
    chk("rst_alu_ctr", 32'(alu_ctr), 32'b0010);
    reset = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;

    do_op(2'b10, 6'b100000, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0);
    do_op(2'b01, 6'b000000, 32'd9, 32'd9, 4'b0110, 32'd0, 1'b1, 1'b0);
    do_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0);
    do_op(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 4'b0111, 32'd0, 1'b1, 1'b0);
    do_op(2'b10, 6'b000000, 32'd3, 32'd4, 4'b1111, 32'd0, 1'b1, 1'b1);
    do_op(2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 1'b0);
    do_op(2'b11, 6'b000000, 32'hF0F0_0000, 32'h0000_0F0F, 4'b0001, 32'hF0F0_0F0F, 1'b0, 1'b0);
    do_op(2'b10, 6'b100010, 32'd10, 32'd3, 4'b0110, 32'd7, 1'b0, 1'b0);
    do_op(2'b10, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000, 32'h0F00_0F00, 1'b0, 1'b0);
    do_op(2'b10, 6'b100101, 32'h0000_00F0, 32'h0000_000F, 4'b0001, 32'h0000_00FF, 1'b0, 1'b0);
    do_op(2'b10, 6'b100111, 32'hFFFF_0000, 32'h0000_FFF0, 4'b1100, 32'h0000_000F, 1'b0, 1'b0);

    // Backpressure: response must hold and a pending request must wait.
    bus.req_valid = 1'b1;
    bus.req_aluop = 2'b00;
    bus.req_a     = 32'd3;
    bus.req_b     = 32'd4;
    @(posedge clk);
    @(negedge clk);
    bus.req_a = 32'd100;
    bus.req_b = 32'd200;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_resp_res", bus.resp_res, 32'd7);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_alu_in1", alu_input1, 32'd3);
      @(posedge clk);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("bp_idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_idle_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_second_in1", alu_input1, 32'd100);
    @(posedge clk);
    @(negedge clk);
    chk("bp_second_res", bus.resp_res, 32'd300);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;

    // Reset while executing abandons the operation.
    bus.req_valid = 1'b1;
    bus.req_aluop = 2'b00;
    bus.req_a     = 32'd20;
    bus.req_b     = 32'd22;
    @(posedge clk);
    @(negedge clk);
    chk("rx_exec_req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    chk("rx_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rx_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rx_resp_res", bus.resp_res, 32'd0);
    chk("rx_alu_ctr", 32'(alu_ctr), 32'b0010);
    chk("rx_alu_in1", alu_input1, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rx_no_resp", 32'(bus.resp_valid), 32'd0);
    chk("rx_still_idle", 32'(bus.req_ready), 32'd1);

    do_op(2'b10, 6'b100000, 32'd1, 32'd2, 4'b0010, 32'd3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  request present.
REQ-005 SHALL have port: req_ready  output  1  unit accepts request.
REQ-006 SHALL have ports: req_a, req_b  input  WIDTH  operands; req_aluop  input  2  main-control ALUOp; req_funct  input  6  R-type funct.
REQ-007 SHALL have ports: alu_input1, alu_input2  output  WIDTH; alu_ctr  output  4  drive the combinational ALU.
REQ-008 SHALL have ports: alu_res  input  WIDTH; alu_zero  input  1  returned from the ALU.
REQ-009 SHALL have ports: resp_valid  output  1; resp_ready  input  1; resp_res  output  WIDTH; resp_zero  output  1; resp_err  output  1  illegal-decode flag.

Function
REQ-010 SHALL implement FSM with states IDLE, EXEC, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-011 SHALL, in IDLE with req_valid=1 at edge k, register req_a, req_b and decoded alu_ctr, and enter EXEC at k.
REQ-012 SHALL hold alu_input1/alu_input2/alu_ctr stable from after edge k until the next accepted request.
REQ-013 SHALL, in EXEC at edge k+1, capture alu_res into resp_res and alu_zero into resp_zero, enter RESP; resp_valid asserted from k+1 (latency 2 edges accept-to-response).
REQ-014 SHALL hold resp_res/resp_zero/resp_err stable while resp_valid=1 and resp_ready=0.
REQ-015 SHALL, in RESP with resp_ready=1 at an edge, return to IDLE; req_valid during RESP is ignored (not accepted); peak throughput one op per 3 cycles.
REQ-016 SHALL decode alu_ctr: ALUOp 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 0001 (or); 10 -> by funct.
REQ-017 SHALL decode funct under ALUOp 10: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
REQ-018 SHALL, for any other funct under ALUOp 10, drive alu_ctr=1111, ignore alu_res/alu_zero, and respond with resp_res=0, resp_zero=1, resp_err=1.
REQ-019 SHALL drive resp_err=0 for every legal decode.
REQ-020 SHALL treat all operands as raw WIDTH-bit vectors; no truncation or extension in this unit.

Reset
REQ-021 SHALL, when reset=1 at an edge, enter IDLE regardless of state, abandoning any in-flight operation without response.
REQ-022 SHALL reset outputs to: req_ready=1 after reset, resp_valid=0, resp_res=0, resp_zero=0, resp_err=0, alu_input1=0, alu_input2=0, alu_ctr=0010.
REQ-023 SHALL give reset priority over req_valid and resp_ready in the same cycle.

Structure
REQ-024 SHALL place ALUOp codes, funct codes, alu_ctr codes (incl. 1111 illegal) and FSM state encodings in shared package alu_pkg.
REQ-025 SHALL implement the decode as combinational sub-module alu_ctrl_decode (inputs aluop, funct; outputs alu_ctr, illegal).
REQ-026 SHALL keep the ALU external; the bench connects the team's ALU to the alu_* ports.

Verification
REQ-027 SHALL cover: ALUOp 10, funct 100000, a=5, b=7 -> alu_ctr=0010, resp_res=12, resp_zero=0, resp_err=0, resp_valid two edges after accept.
REQ-028 SHALL cover: ALUOp 01, a=9, b=9 -> alu_ctr=0110, resp_res=0, resp_zero=1.
REQ-029 SHALL cover: ALUOp 10, funct 101010, a=0xFFFFFFFF, b=1 -> alu_ctr=0111, resp_res=1; swapped operands -> resp_res=0.
REQ-030 SHALL cover: ALUOp 10, funct 000000 -> alu_ctr=1111, resp_res=0, resp_zero=1, resp_err=1.
REQ-031 SHALL cover: resp_ready held 0 for 5 cycles with req_valid=1 throughout -> response stable, req_ready=0, no second accept until RESP->IDLE.
REQ-032 SHALL cover: reset asserted in EXEC -> next cycle IDLE, resp_valid=0, req_ready=1, no response for the abandoned op.
